// File: rtl/axi_cmd_arbiter.sv
// axi_cmd_arbiter: write-clock-domain front end of the AXI4-Lite to APB bridge.
// Collects AW/W/AR transfers into single-entry holding registers, merges them
// into one command word per transaction, arbitrates round-robin between write
// and read, and pushes the winner into the command FIFO under credit control.
module axi_cmd_arbiter #(
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int STRB_WIDTH      = DATA_WIDTH / 8,
    localparam int CMD_WIDTH       = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH,
    localparam int CNT_WIDTH       = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic                  fifo_winc,
    output logic [CMD_WIDTH-1:0]  fifo_wdata,
    input  logic                  fifo_wfull,
    input  logic                  resp_done,
    output logic [CNT_WIDTH-1:0]  outstanding
);

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_e;

    // Holding-register control flags and round-robin pointer (reset).
    logic   aw_full;
    logic   w_full;
    logic   ar_full;
    grant_e last_grant;

    // Holding-register payloads (not reset: only consumed while the flag is set).
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic [ADDR_WIDTH-1:0] ar_addr;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic wr_req;
    logic rd_req;
    logic can_issue;
    logic issue_wr;
    logic issue_rd;

    // Credit update: +1 on issue, -1 on a completion, never below zero.
    // The upper bound is enforced by can_issue, so no clamp is needed there.
    function automatic logic [CNT_WIDTH-1:0] credit_next(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc,
        input logic                 dec
    );
        logic dec_ok;
        dec_ok = dec && (cnt != '0);
        if (inc && !dec_ok)
            return cnt + 1'b1;
        else if (!inc && dec_ok)
            return cnt - 1'b1;
        else
            return cnt;
    endfunction

    // Readies come straight from the flags so no valid-to-ready path exists.
    assign s_awready = !aw_full;
    assign s_wready  = !w_full;
    assign s_arready = !ar_full;

    assign aw_hs = s_awvalid && !aw_full;
    assign w_hs  = s_wvalid  && !w_full;
    assign ar_hs = s_arvalid && !ar_full;

    assign wr_req    = aw_full && w_full;
    assign rd_req    = ar_full;
    assign can_issue = !fifo_wfull && (outstanding < CNT_WIDTH'(MAX_OUTSTANDING));

    // Round-robin grant: a lone request wins; a tie goes opposite to last_grant.
    always_comb begin
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        if (can_issue) begin
            if (wr_req && rd_req) begin
                issue_wr = (last_grant == GNT_READ);
                issue_rd = (last_grant == GNT_WRITE);
            end else begin
                issue_wr = wr_req;
                issue_rd = rd_req;
            end
        end
    end

    assign fifo_winc = issue_wr || issue_rd;

    // Command word {is_write, addr, data, strb}; zero whenever nothing is pushed.
    always_comb begin
        fifo_wdata = '0;
        if (issue_wr)
            fifo_wdata = {1'b1, aw_addr, w_data, w_strb};
        else if (issue_rd)
            fifo_wdata = {1'b0, ar_addr, {DATA_WIDTH{1'b0}}, {STRB_WIDTH{1'b0}}};
    end

    // Control state: holding flags, arbitration pointer and credit counter.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            ar_full     <= 1'b0;
            last_grant  <= GNT_READ;
            outstanding <= '0;
        end else begin
            if (issue_wr)
                aw_full <= 1'b0;
            else if (aw_hs)
                aw_full <= 1'b1;

            if (issue_wr)
                w_full <= 1'b0;
            else if (w_hs)
                w_full <= 1'b1;

            if (issue_rd)
                ar_full <= 1'b0;
            else if (ar_hs)
                ar_full <= 1'b1;

            if (issue_wr)
                last_grant <= GNT_WRITE;
            else if (issue_rd)
                last_grant <= GNT_READ;

            outstanding <= credit_next(outstanding, fifo_winc, resp_done);
        end
    end

    // Payload capture on each channel handshake.
    always_ff @(posedge wclk) begin
        if (aw_hs)
            aw_addr <= s_awaddr;
        if (w_hs) begin
            w_data <= s_wdata;
            w_strb <= s_wstrb;
        end
        if (ar_hs)
            ar_addr <= s_araddr;
    end

endmodule
